// File: rtl/pbs_turn_ctrl.sv
// Battle-turn sequencer: player hits AI, then AI hits player, with KO detection and winner.
// Optional TURN_LIMIT_EN ends the battle after MAX_TURNS turns (higher HP wins, tie -> AI).
module pbs_turn_ctrl #(
  parameter int SETTLE    = 2,
  parameter int TURN_W    = 8,
  parameter int MAX_TURNS = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [1:0]        p_move_in,
  input  logic [4:0]        p_hp,
  input  logic [4:0]        AI_hp,
  output logic [1:0]        p_move,
  output logic              actr,
  output logic              target,
  output logic              app_dmg,
  output logic              stop,
  output logic              busy,
  output logic              game_over,
  output logic              winner,
  output logic [TURN_W-1:0] turn_cnt,
  output logic [2:0]        state_dbg
);

  if (SETTLE < 1 || SETTLE > 7 || MAX_TURNS < 1) begin : g_bad_param
    $error("pbs_turn_ctrl: SETTLE must be 1..7 and MAX_TURNS >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, P_SET, P_HIT, P_CHK, A_SET, A_HIT, A_CHK, OVER
  } state_t;

  localparam logic [2:0] SETTLE_C = 3'(SETTLE);

  state_t              state, nxt;
  logic [2:0]          cnt, cnt_nxt;
  logic [1:0]          move_nxt;
  logic                win_nxt;
  logic [TURN_W-1:0]   turn_nxt;

  assign state_dbg = state;

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    move_nxt = p_move;
    win_nxt  = winner;
    turn_nxt = turn_cnt;
    case (state)
      IDLE: begin
        if (go) begin
          if (p_hp == 5'd0) begin
            nxt     = OVER;
            win_nxt = 1'b1;
          end else if (AI_hp == 5'd0) begin
            nxt     = OVER;
            win_nxt = 1'b0;
          end else begin
            nxt      = P_SET;
            move_nxt = p_move_in;
            cnt_nxt  = SETTLE_C;
          end
        end
      end
      P_SET: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) nxt = P_HIT;
      end
      P_HIT: nxt = P_CHK;
      P_CHK: begin
        if (AI_hp == 5'd0) begin
          nxt     = OVER;
          win_nxt = 1'b0;
        end else begin
          nxt     = A_SET;
          cnt_nxt = SETTLE_C;
        end
      end
      A_SET: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) nxt = A_HIT;
      end
      A_HIT: nxt = A_CHK;
      A_CHK: begin
        if (p_hp == 5'd0) begin
          nxt     = OVER;
          win_nxt = 1'b1;
        end else begin
          nxt = IDLE;
          if (turn_cnt != '1) turn_nxt = turn_cnt + TURN_W'(1);
`ifdef TURN_LIMIT_EN
          if ((TURN_W+1)'(turn_cnt) + (TURN_W+1)'(1) == (TURN_W+1)'(MAX_TURNS)) begin
            nxt     = OVER;
            win_nxt = (p_hp > AI_hp) ? 1'b0 : 1'b1;
          end
`endif
        end
      end
      OVER:    nxt = OVER;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change together with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      p_move    <= 2'd0;
      winner    <= 1'b0;
      turn_cnt  <= '0;
      actr      <= 1'b0;
      target    <= 1'b0;
      app_dmg   <= 1'b0;
      stop      <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      p_move    <= move_nxt;
      winner    <= win_nxt;
      turn_cnt  <= turn_nxt;
      actr      <= (nxt == A_SET) || (nxt == A_HIT) || (nxt == A_CHK);
      target    <= (nxt == P_SET) || (nxt == P_HIT) || (nxt == P_CHK);
      app_dmg   <= (nxt == P_HIT) || (nxt == A_HIT);
      stop      <= (nxt == A_SET) || (nxt == A_HIT);
      busy      <= (nxt != IDLE) && (nxt != OVER);
      game_over <= (nxt == OVER);
    end
  end

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Bench for pbs_turn_ctrl: directed timing/reset sequences, a vector table and randomized games
// checked against an HP-arithmetic battle model; a small datapath model applies the damage.
module tb_pbs_turn_ctrl;
  localparam int SETTLE    = 2;
  localparam int TURN_W    = 8;
  localparam int MAX_TURNS = 3;
  localparam int PERIOD    = 2*SETTLE + 5;

  logic              clk = 1'b0;
  logic              rst, go;
  logic [1:0]        p_move_in;
  logic [4:0]        p_hp, ai_hp;
  logic [1:0]        p_move;
  logic              actr, target, app_dmg, stop, busy, game_over, winner;
  logic [TURN_W-1:0] turn_cnt;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] dmg_ai, dmg_p;
  int   pulses, stops;
  logic prev_hit, consec;

  logic [4:0] m_p, m_ai;
  logic [1:0] m_move;
  logic       m_over, m_win;
  int         m_turns;

  typedef struct {
    logic [4:0] p0, a0, dp, da;
    int         turns;
    logic       exp_over, exp_win;
    int         exp_turns;
  } vec_t;
  vec_t vecs[7];

  pbs_turn_ctrl #(.SETTLE(SETTLE), .TURN_W(TURN_W), .MAX_TURNS(MAX_TURNS)) dut (
    .clk(clk), .rst(rst), .go(go), .p_move_in(p_move_in), .p_hp(p_hp), .AI_hp(ai_hp),
    .p_move(p_move), .actr(actr), .target(target), .app_dmg(app_dmg), .stop(stop),
    .busy(busy), .game_over(game_over), .winner(winner), .turn_cnt(turn_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: observe at negedge, let the datapath apply a strobed hit just after the edge.
  task automatic tick();
    logic hit, tgt;
    hit = app_dmg;
    tgt = target;
    if (hit) pulses++;
    if (stop) stops++;
    if (hit && prev_hit) consec = 1'b1;
    prev_hit = hit;
    @(posedge clk);
    #1;
    if (hit) begin
      if (tgt) ai_hp = (ai_hp > dmg_ai) ? ai_hp - dmg_ai : 5'd0;
      else     p_hp  = (p_hp > dmg_p)   ? p_hp - dmg_p   : 5'd0;
    end
    @(negedge clk);
  endtask

  task automatic clear_mon();
    pulses = 0; stops = 0; prev_hit = 1'b0; consec = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; go = 1'b0;
    tick(); tick();
    rst = 1'b1;
    clear_mon();
  endtask

  task automatic play_turn(input logic [1:0] mv);
    int k;
    clear_mon();
    p_move_in = mv; go = 1'b1;
    tick();
    go = 1'b0;
    p_move_in = ~mv;
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    check("turn_end_busy", busy, 1'b0);
  endtask

  // Battle rules as plain HP arithmetic: one turn, returns the expected number of hits.
  task automatic model_turn(input logic [1:0] mv, output int ep);
    ep = 0;
    if (m_p == 5'd0) begin m_over = 1'b1; m_win = 1'b1; end
    else if (m_ai == 5'd0) begin m_over = 1'b1; m_win = 1'b0; end
    else begin
      m_move = mv;
      m_ai = (m_ai > dmg_ai) ? m_ai - dmg_ai : 5'd0;
      ep = 1;
      if (m_ai == 5'd0) begin m_over = 1'b1; m_win = 1'b0; end
      else begin
        m_p = (m_p > dmg_p) ? m_p - dmg_p : 5'd0;
        ep = 2;
        if (m_p == 5'd0) begin m_over = 1'b1; m_win = 1'b1; end
        else begin
          if (m_turns < 255) m_turns++;
`ifdef TURN_LIMIT_EN
          if (m_turns == MAX_TURNS) begin m_over = 1'b1; m_win = (m_p > m_ai) ? 1'b0 : 1'b1; end
`endif
        end
      end
    end
  endtask

  task automatic play_game(input logic [4:0] p0, a0, dp, da, input int max_turns);
    int ep;
    logic [1:0] mv;
    p_hp = p0; ai_hp = a0; dmg_ai = dp; dmg_p = da;
    do_reset();
    m_p = p0; m_ai = a0; m_move = 2'd0; m_over = 1'b0; m_win = 1'b0; m_turns = 0;
    for (int t = 0; t < max_turns && !m_over; t++) begin
      mv = 2'($urandom_range(0, 3));
      play_turn(mv);
      model_turn(mv, ep);
      check("g_pulses", pulses, ep);
      check("g_stop_cycles", stops, (ep == 2) ? SETTLE + 1 : 0);
      check("g_consec_dmg", consec, 1'b0);
      check("g_turn_cnt", turn_cnt, m_turns);
      check("g_game_over", game_over, m_over);
      check("g_p_move", p_move, m_move);
      check("g_hp", {p_hp, ai_hp}, {m_p, m_ai});
      if (m_over) check("g_winner", winner, m_win);
    end
    if (m_over) begin
      clear_mon();
      go = 1'b1;
      repeat (2*PERIOD) tick();
      go = 1'b0;
      check("over_no_strobe", pulses, 0);
      check("over_held", game_over, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{5'd15, 5'd15, 5'd1,  5'd1, 2, 1'b0, 1'b0, 2};
    vecs[1] = '{5'd15, 5'd3,  5'd3,  5'd1, 3, 1'b1, 1'b0, 0};
    vecs[2] = '{5'd2,  5'd15, 5'd1,  5'd2, 3, 1'b1, 1'b1, 0};
    vecs[3] = '{5'd0,  5'd5,  5'd1,  5'd1, 2, 1'b1, 1'b1, 0};
    vecs[4] = '{5'd5,  5'd0,  5'd1,  5'd1, 2, 1'b1, 1'b0, 0};
`ifdef TURN_LIMIT_EN
    vecs[5] = '{5'd4,  5'd10, 5'd3,  5'd1, 6, 1'b1, 1'b1, 3};
`else
    vecs[5] = '{5'd4,  5'd10, 5'd3,  5'd1, 6, 1'b1, 1'b0, 3};
`endif
    vecs[6] = '{5'd31, 5'd31, 5'd31, 5'd0, 3, 1'b1, 1'b0, 0};

    rst = 1'b0; go = 1'b0; p_move_in = 2'd0; p_hp = 5'd15; ai_hp = 5'd15;
    dmg_ai = 5'd1; dmg_p = 5'd1;
    clear_mon();
    @(negedge clk);
    do_reset();
    check("rst_outputs", {actr, target, app_dmg, stop, busy, game_over, winner}, 7'd0);
    check("rst_state", state_dbg, 3'd0);
    check("rst_turn_cnt", turn_cnt, 0);
    check("rst_p_move", p_move, 2'd0);

    // Cycle-by-cycle turn timing; k counts cycles after the edge that samples go.
    p_move_in = 2'd2; go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k <= 2*SETTLE + 4; k++) begin
      if (k == 1) p_move_in = 2'd1;
      check("t_app_dmg", app_dmg, (k == SETTLE) || (k == 2*SETTLE + 2));
      check("t_stop", stop, (k >= SETTLE + 2) && (k <= 2*SETTLE + 2));
      check("t_busy", busy, k <= 2*SETTLE + 3);
      check("t_p_move", p_move, 2'd2);
      check("t_turn_cnt", turn_cnt, (k == 2*SETTLE + 4) ? 1 : 0);
      if (k <= SETTLE) begin
        check("t_p_actr", actr, 1'b0);
        check("t_p_target", target, 1'b1);
      end
      if (k >= SETTLE + 2 && k <= 2*SETTLE + 2) begin
        check("t_a_actr", actr, 1'b1);
        check("t_a_target", target, 1'b0);
      end
      if (k < 2*SETTLE + 4) tick();
    end
    check("t_hp", {p_hp, ai_hp}, {5'd14, 5'd14});

    // Reset in the middle of the AI settle phase, then a clean restart.
    p_move_in = 2'd3; go = 1'b1;
    tick();
    go = 1'b0;
    repeat (SETTLE + 2) tick();
    check("mid_stop_before_rst", stop, 1'b1);
    rst = 1'b0;
    tick();
    check("mid_rst_outputs", {actr, target, app_dmg, stop, busy, game_over, winner}, 7'd0);
    check("mid_rst_state", state_dbg, 3'd0);
    check("mid_rst_p_move", p_move, 2'd0);
    rst = 1'b1;
    p_move_in = 2'd1; go = 1'b1;
    tick();
    go = 1'b0;
    check("restart_p_move", p_move, 2'd1);
    check("restart_busy_target", {busy, target, actr}, 3'b110);

    // go held high across three turns.
    p_hp = 5'd15; ai_hp = 5'd15; dmg_ai = 5'd1; dmg_p = 5'd1;
    do_reset();
    go = 1'b1;
    tick();
    repeat (2*PERIOD) tick();
    go = 1'b0;
    for (int k = 0; k < 40 && busy; k++) tick();
    check("hold_turn_cnt", turn_cnt, 3);
    check("hold_hp", {p_hp, ai_hp}, {5'd12, 5'd12});
    check("hold_pulses", pulses, 6);
    check("hold_consec", consec, 1'b0);
`ifdef TURN_LIMIT_EN
    check("hold_game_over", game_over, 1'b1);
    check("hold_winner_tie", winner, 1'b1);
`else
    check("hold_game_over", game_over, 1'b0);
`endif

    foreach (vecs[i]) begin
      play_game(vecs[i].p0, vecs[i].a0, vecs[i].dp, vecs[i].da, vecs[i].turns);
      check("vec_game_over", game_over, vecs[i].exp_over);
      check("vec_winner", winner, vecs[i].exp_win);
      check("vec_turn_cnt", turn_cnt, vecs[i].exp_turns);
    end

    for (int g = 0; g < 16; g++) begin
      play_game(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                5'($urandom_range(1, 8)), 5'($urandom_range(1, 8)), 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
